// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-engine state encoding and character constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_serializer.sv
// Single-word 8N1 frame engine paced by the 16x baud tick. A start request
// coinciding with frame_done chains the next frame with no idle gap.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 tx,
    output logic                 frame_done
);

    localparam int              BIT_W     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]      STOP_LAST = 4'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

    uart_state_t          state, state_nxt;
    logic [3:0]           tick_cnt, tick_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [DATA_SIZE-1:0] shift, shift_nxt;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    // Data path carries no reset; it is always loaded before it reaches the line.
    always_ff @(posedge clk_100MHz) begin
        shift <= shift_nxt;
    end

    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift;
        tx         = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                    shift_nxt = din;
                end
            end
            START: begin
                tx = 1'b0;
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_nxt = DATA;
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                tx = shift[0];
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt  = '0;
                        shift_nxt = shift >> 1;
                        if (bit_cnt == BIT_LAST) state_nxt = STOP;
                        else                     bit_nxt   = bit_cnt + BIT_W'(1);
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        tick_nxt   = '0;
                        if (start) begin
                            state_nxt = START;
                            shift_nxt = din;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_msg_tx.sv
// Multi-word message transmitter: latches msg_in on send and streams word 0
// first as back-to-back 8N1 frames. Define UART_TX_CRLF_EN to append CR, LF.
module uart_msg_tx
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int MSG_BYTES = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                           clk_100MHz,
    input  logic                           reset,
    input  logic                           s_tick,
    input  logic                           send,
    input  logic [DATA_SIZE*MSG_BYTES-1:0] msg_in,
    output logic                           busy,
    output logic                           done,
    output logic                           tx
);

    localparam int MSG_W = DATA_SIZE * MSG_BYTES;
`ifdef UART_TX_CRLF_EN
    localparam int TOTAL_WORDS = MSG_BYTES + 2;
`else
    localparam int TOTAL_WORDS = MSG_BYTES;
`endif
    localparam int              CNT_W     = $clog2(TOTAL_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL_WORDS - 1);

    logic [MSG_W-1:0]     msg_reg;
    logic [CNT_W-1:0]     byte_cnt, next_idx;
    logic [DATA_SIZE-1:0] next_word, ser_din;
    logic                 accept, last_frame, frame_done, ser_start;

    assign accept     = send & ~busy;
    assign last_frame = (byte_cnt == LAST_WORD);
    assign next_idx   = byte_cnt + CNT_W'(1);
    assign ser_start  = accept | (frame_done & ~last_frame);
    // The first word bypasses msg_reg so the start bit begins on the accepting edge.
    assign ser_din    = busy ? next_word : msg_in[MSG_W-1 -: DATA_SIZE];

    always_comb begin
        next_word = '0;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (next_idx == CNT_W'(i)) next_word = msg_reg[(MSG_BYTES-1-i)*DATA_SIZE +: DATA_SIZE];
        end
`ifdef UART_TX_CRLF_EN
        if (next_idx == CNT_W'(MSG_BYTES))     next_word = DATA_SIZE'(ASCII_CR);
        if (next_idx == CNT_W'(MSG_BYTES + 1)) next_word = DATA_SIZE'(ASCII_LF);
`endif
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                byte_cnt <= '0;
            end else if (frame_done) begin
                if (last_frame) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    byte_cnt <= next_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (accept) msg_reg <= msg_in;
    end

    uart_tx_serializer #(
        .DATA_SIZE (DATA_SIZE),
        .SB_TICKS  (SB_TICKS)
    ) u_serializer (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .s_tick     (s_tick),
        .start      (ser_start),
        .din        (ser_din),
        .tx         (tx),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx: an independent 8N1 line decoder plus tick
// and done counters, checked against hand-chosen messages.
module tb_uart_msg_tx;

    localparam int DATA_SIZE = 8;
    localparam int MSG_BYTES = 8;
    localparam int SB_TICKS  = 16;
`ifdef UART_TX_CRLF_EN
    localparam int TOTAL = MSG_BYTES + 2;
`else
    localparam int TOTAL = MSG_BYTES;
`endif
    localparam int MSG_TICKS = 160 * TOTAL;
    localparam int DONE_LIMIT = MSG_TICKS * 4 + 400;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic        s_tick     = 1'b0;
    logic        send       = 1'b0;
    logic [63:0] msg_in     = '0;
    logic        busy, done, tx;

    uart_msg_tx #(
        .DATA_SIZE (DATA_SIZE),
        .MSG_BYTES (MSG_BYTES),
        .SB_TICKS  (SB_TICKS)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .s_tick     (s_tick),
        .send       (send),
        .msg_in     (msg_in),
        .busy       (busy),
        .done       (done),
        .tx         (tx)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic       tick_en     = 1'b0;
    int         div         = 0;
    bit         rx_active   = 1'b0;
    int         rx_cnt      = 0;
    logic [7:0] rx_sh       = '0;
    logic [7:0] rx_q[$];
    int         ticks_msg   = 0;
    int         done_pulses = 0;
    int         tx_toggles  = 0;
    logic       busy_q      = 1'b0;
    logic       tx_q        = 1'b1;

    // On each falling edge, s_tick still holds the value the DUT consumed at
    // the preceding rising edge; observe first, then advance the tick generator.
    always @(negedge clk_100MHz) begin
        if (!reset) begin
            rx_active = 1'b0;
            busy_q    = 1'b0;
            ticks_msg = 0;
        end else begin
            if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else if (s_tick) begin
                rx_cnt++;
                if (rx_cnt == 8) check("start_bit", 32'(tx), 32'd0);
                else if (rx_cnt >= 24 && rx_cnt <= 136 && (rx_cnt - 24) % 16 == 0) rx_sh = {tx, rx_sh[7:1]};
                else if (rx_cnt == 152) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(rx_sh);
                    rx_active = 1'b0;
                end
            end
            if (!busy_q && busy) ticks_msg = 0;
            else if (busy_q && s_tick) ticks_msg++;
            busy_q = busy;
            if (done) done_pulses++;
        end
        if (tx !== tx_q) tx_toggles++;
        tx_q = tx;
        if (tick_en) begin
            div    = (div + 1) % 4;
            s_tick = (div == 0);
        end else begin
            s_tick = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < DONE_LIMIT; i++) begin
            @(posedge clk_100MHz);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] m, input int i);
        if (i < MSG_BYTES) return m[63 - 8*i -: 8];
        if (i == MSG_BYTES) return 8'h0D;
        return 8'h0A;
    endfunction

    task automatic check_bytes(input string tag, input logic [63:0] m, input int base);
        for (int i = 0; i < TOTAL; i++) begin
            if (base + i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base + i]), 32'(exp_byte(m, i)));
            else
                check($sformatf("%s_byte%0d_missing", tag, i), 32'(rx_q.size()), 32'(base + TOTAL));
        end
    endtask

    task automatic pulse_send(input logic [63:0] m);
        msg_in = m;
        send   = 1'b1;
        cycles(1);
        send   = 1'b0;
    endtask

    localparam logic [63:0] MSG_SIMON = 64'h53494D4F4E534159;
    localparam logic [63:0] MSG_A     = 64'h48454C4C4F313233;
    localparam logic [63:0] MSG_A2    = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] MSG_B     = 64'h00FFA55A01807FFE;
    localparam logic [63:0] MSG_C     = 64'h0123456789ABCDEF;
    localparam logic [63:0] MSG_D     = 64'h123456789ABCDEF0;

    initial begin
        // Reset state
        cycles(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        cycles(2);
        tick_en = 1'b1;
        cycles(5);

        // SIMONSAY: acceptance latency, byte order, tick count, single done
        rx_q.delete();
        done_pulses = 0;
        msg_in = MSG_SIMON;
        send   = 1'b1;
        cycles(1);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_tx", 32'(tx), 32'd0);
        send = 1'b0;
        wait_done("simon");
        check("simon_busy_at_done", 32'(busy), 32'd0);
        cycles(4);
        check("simon_ticks", 32'(ticks_msg), 32'(MSG_TICKS));
        check("simon_done_pulses", 32'(done_pulses), 32'd1);
        check("simon_nbytes", 32'(rx_q.size()), 32'(TOTAL));
        check_bytes("simon", MSG_SIMON, 0);
        check("simon_idle_tx", 32'(tx), 32'd1);

        // send held high, msg_in changed mid-message
        rx_q.delete();
        msg_in = MSG_A;
        send   = 1'b1;
        cycles(200);
        msg_in = MSG_A2;
        cycles(2000);
        check("held_busy", 32'(busy), 32'd1);
        wait_done("held");
        send = 1'b0;
        cycles(50);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_tx", 32'(tx), 32'd1);
        check("held_nbytes", 32'(rx_q.size()), 32'(TOTAL));
        check_bytes("held", MSG_A, 0);

        // Back-to-back: send raised in the done cycle
        rx_q.delete();
        pulse_send(MSG_B);
        wait_done("b2b_first");
        msg_in = MSG_C;
        send   = 1'b1;
        cycles(1);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_tx", 32'(tx), 32'd0);
        check("b2b_done_low", 32'(done), 32'd0);
        send = 1'b0;
        wait_done("b2b_second");
        cycles(4);
        check("b2b_ticks", 32'(ticks_msg), 32'(MSG_TICKS));
        check("b2b_nbytes", 32'(rx_q.size()), 32'(2 * TOTAL));
        check_bytes("b2b_first", MSG_B, 0);
        check_bytes("b2b_second", MSG_C, TOTAL);

        // s_tick frozen for 1000 cycles mid-bit
        rx_q.delete();
        pulse_send(MSG_D);
        cycles(300);
        tick_en = 1'b0;
        cycles(2);
        tx_toggles = 0;
        cycles(1000);
        check("freeze_toggles", 32'(tx_toggles), 32'd0);
        check("freeze_busy", 32'(busy), 32'd1);
        tick_en = 1'b1;
        wait_done("freeze");
        cycles(4);
        check("freeze_ticks", 32'(ticks_msg), 32'(MSG_TICKS));
        check_bytes("freeze", MSG_D, 0);

        // Asynchronous reset mid-DATA
        rx_q.delete();
        pulse_send(MSG_SIMON);
        cycles(200);
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        cycles(3);
        reset = 1'b1;
        tx_toggles = 0;
        cycles(300);
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_toggles", 32'(tx_toggles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
